// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD-to-binary converter
//
// Purpose: FSM state encoding, default sizing and a counter-width helper
// shared by bcd_to_bin and its test bench.
// Ports: none (package).
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGITS_DEF = 8;
  localparam int BIN_W_DEF  = 32;
  localparam int CNT_W_DEF  = $clog2(BIN_W_DEF + 1);

  // Counter must hold the value BIN_W itself (the latch step follows the
  // last iteration), hence +1.
  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - one-digit reverse double-dabble correction
//
// Purpose: after a right shift, a BCD digit that reads >=8 received a carried-in
// bit worth 8 that is really worth 5 in decimal, so subtract 3.
// Ports:
//   digit  in  4  BCD digit after the shift
//   adj    out 4  corrected digit
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adj
);

  assign adj = (digit >= 4'd8) ? (digit - 4'd3) : digit;

endmodule

// File: rtl/bcd_to_bin.sv
// rtl/bcd_to_bin.sv - iterative packed-BCD to binary converter with ready/valid
//
// Purpose: converts a DIGITS-digit packed BCD word to binary, one bit per clock,
// by reverse double-dabble over a {bcd, bin} work register.
// Optional feature: define BCD_CHECK_EN to flag non-decimal digits on err and
// force bin_out to 0 for such inputs; otherwise err is tied to 0.
// Ports:
//   clk        in   1         system clock
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         bcd_in is valid
//   in_ready   out  1         converter is idle and accepts input
//   bcd_in     in   4*DIGITS  packed BCD, digit 0 in bits [3:0]
//   out_valid  out  1         bin_out/err hold a result
//   out_ready  in   1         consumer takes the result
//   bin_out    out  BIN_W     binary result
//   err        out  1         input had a digit above 9 (BCD_CHECK_EN only)
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int BIN_W  = BIN_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIN_W-1:0]    bin_out,
  output logic                err
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = cnt_width(BIN_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W);

  state_t             state;
  state_t             state_next;
  logic [WORK_W-1:0]  work;
  logic [WORK_W-1:0]  work_shift;
  logic [WORK_W-1:0]  work_next;
  logic [CNT_W-1:0]   cnt;
  logic               accept;
  logic               conv_done;
  logic [BIN_W-1:0]   bin_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake outputs depend on the registered state only.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    conv_done  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        // cnt == BIN_W means all shifts are done; this cycle only latches.
        if (cnt == LAST_CNT) begin
          conv_done  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // BCD LSB falls into the bin MSB; then each digit is corrected.
  assign work_shift = work >> 1;
  assign work_next[BIN_W-1:0] = work_shift[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (work_shift[BIN_W + 4*g +: 4]),
      .adj   (work_next[BIN_W + 4*g +: 4])
    );
  end

`ifdef BCD_CHECK_EN
  logic bad_digit;
  logic err_flag;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Flag is captured with the input; err itself only moves on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_flag <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (accept) begin
        err_flag <= bad_digit;
      end
      if (conv_done) begin
        err <= err_flag;
      end
    end
  end

  assign bin_result = err_flag ? '0 : work[BIN_W-1:0];
`else
  assign err        = 1'b0;
  assign bin_result = work[BIN_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work    <= '0;
      cnt     <= '0;
      bin_out <= '0;
    end else begin
      if (accept) begin
        work <= {bcd_in, {BIN_W{1'b0}}};
        cnt  <= '0;
      end else if (state == CONV && !conv_done) begin
        work <= work_next;
        cnt  <= cnt + CNT_W'(1);
      end
      if (conv_done) begin
        bin_out <= bin_result;
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb/tb_bcd_to_bin.sv - directed self-checking bench for bcd_to_bin
//
// Purpose: directed conversions with hand-computed results, latency, reset,
// backpressure and back-to-back checks. BCD_CHECK_EN adds the err cases.
// Ports: none (top-level bench).
module tb_bcd_to_bin;

  localparam int LAT = 33;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] bcd_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] bin_out;
  logic        err;

  int checks;
  int errors;

  bcd_to_bin dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .bcd_in    (bcd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bin_out   (bin_out),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Present one word, wait for the result with out_ready low, check it, then
  // complete the output handshake.
  task automatic convert(input string tag, input logic [31:0] bcd,
                         input logic [31:0] exp_bin, input logic exp_err);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    bcd_in   = bcd;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_bin"}, bin_out, exp_bin);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  logic [31:0] b2b_in  [4];
  logic [31:0] b2b_exp [4];
  int          cyc;
  int          acc_cyc [4];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_in    = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_bin", bin_out, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    convert("zero", 32'h0000_0000, 32'h0000_0000, 1'b0);
    convert("d1234", 32'h0000_1234, 32'h0000_04D2, 1'b0);
    convert("max", 32'h9999_9999, 32'h05F5_E0FF, 1'b0);
    convert("d10", 32'h0000_0010, 32'h0000_000A, 1'b0);
`ifdef BCD_CHECK_EN
    convert("bad_a", 32'h0000_000A, 32'h0000_0000, 1'b1);
    convert("after_bad", 32'h0000_0010, 32'h0000_000A, 1'b0);
`endif

    // Backpressure: result must hold while out_ready stays low.
    begin
      int lat;
      @(negedge clk);
      bcd_in   = 32'h0000_1234;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 60) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("bp_latency", 32'(lat), 32'(LAT));
      for (int i = 0; i < 10; i++) begin
        in_valid = i[0];
        bcd_in   = 32'h0000_0777 + 32'(i);
        @(posedge clk);
        #1;
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_bin", bin_out, 32'h0000_04D2);
        check("bp_err", 32'(err), 32'd0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_release", 32'(out_valid), 32'd0);
      check("bp_no_queue", 32'(in_ready), 32'd1);
    end

    // Asynchronous reset in the middle of a conversion.
    @(negedge clk);
    bcd_in   = 32'h0000_5678;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_bin", bin_out, 32'h0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    convert("post_rst", 32'h0000_0042, 32'h0000_002A, 1'b0);

    // Back-to-back with in_valid and out_ready held high.
    b2b_in[0] = 32'h0000_0001; b2b_exp[0] = 32'h0000_0001;
    b2b_in[1] = 32'h0000_0255; b2b_exp[1] = 32'h0000_00FF;
    b2b_in[2] = 32'h0006_5536; b2b_exp[2] = 32'h0001_0000;
    b2b_in[3] = 32'h1234_5678; b2b_exp[3] = 32'h00BC_614E;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int t;
          @(negedge clk);
          bcd_in   = b2b_in[i];
          in_valid = 1'b1;
          t = 0;
          while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
          end
          @(posedge clk);
          #1;
          acc_cyc[i] = cyc;
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin
        int got;
        int t;
        got = 0;
        t   = 0;
        while (got < 4 && t < 400) begin
          @(negedge clk);
          t++;
          if (out_valid) begin
            check("b2b_bin", bin_out, b2b_exp[got]);
            check("b2b_latency", 32'(cyc - acc_cyc[got]), 32'(LAT));
            got++;
          end
        end
        check("b2b_count", 32'(got), 32'd4);
      end
    join
    out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
